// File: rtl/password_entry_collector.sv
// -----------------------------------------------------------------------------
// password_entry_collector
//
// Purpose:
//   Sits behind the keypad decoder and assembles successive digit keys into a
//   single password packet. The packet is published when the confirm key is
//   pressed, through a valid/ready handshake to the lock comparison FSM. An
//   inter-key timeout discards an entry that the user abandoned.
//
// Ports:
//   clk           in   system clock, all logic on the rising edge
//   rst           in   asynchronous active-low reset (0 = reset)
//   enable        in   0 clears the block synchronously and ignores keys
//   key_valid     in   key strobe from the decoder; may be held for many cycles
//   key_value     in   key code: 0-9 digit, CONFIRM_KEY confirm, 4'hF none
//   senha_digits  out  packed digits, [3:0] newest, unused nibbles 4'hF
//   senha_count   out  number of valid digits in senha_digits
//   senha_valid   out  packet available; held until senha_ready
//   senha_ready   in   consumer takes the packet when high with senha_valid
//   timeout_evt   out  one-cycle pulse when a partial entry is discarded
// -----------------------------------------------------------------------------
module password_entry_collector #(
  parameter int          MAX_DIGITS     = 20,
  parameter int          TIMEOUT_CYCLES = 5000,
  parameter logic [3:0]  CONFIRM_KEY    = 4'hA
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              key_valid,
  input  logic [3:0]                        key_value,
  output logic [4*MAX_DIGITS-1:0]           senha_digits,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   senha_count,
  output logic                              senha_valid,
  input  logic                              senha_ready,
  output logic                              timeout_evt
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  // Guard against a degenerate zero-width timer for tiny timeouts.
  localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int DW = 4 * MAX_DIGITS;

  localparam logic [CW-1:0] COUNT_MAX   = CW'(MAX_DIGITS);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_SAT   = {TW{1'b1}};
  localparam logic [DW-1:0] DIGITS_NONE = {DW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  state_t          state_q,  state_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [TW-1:0]   timer_q,  timer_d;
  logic            tevt_q,   tevt_d;
  logic            key_valid_q;

  logic            key_evt;
  logic            digit_evt;
  logic            confirm_evt;
  logic [DW-1:0]   digits_shifted;
  logic [CW-1:0]   count_inc;
  logic [TW-1:0]   timer_inc;

  // One event per press: only the rising edge of key_valid counts.
  assign key_evt     = key_valid & ~key_valid_q;
  assign digit_evt   = key_evt & (key_value <= 4'd9);
  assign confirm_evt = key_evt & (key_value == CONFIRM_KEY);

  // Shift every nibble up one slot and insert the new key at the bottom.
  // The top nibble falls off, which is how the oldest digit is dropped once
  // the buffer is full.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_DIGITS; gi++) begin : g_shift
      if (gi == 0) begin : g_newest
        assign digits_shifted[3:0] = key_value;
      end else begin : g_older
        assign digits_shifted[4*gi +: 4] = digits_q[4*(gi-1) +: 4];
      end
    end
  endgenerate

  assign count_inc = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
  assign timer_inc = (timer_q == TIMER_SAT) ? timer_q : timer_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    timer_d  = timer_q;
    tevt_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Confirm with nothing entered is meaningless and is dropped.
        if (digit_evt) begin
          digits_d = digits_shifted;
          count_d  = count_inc;
          timer_d  = '0;
          state_d  = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // A key arriving in the expiry cycle takes priority over the timeout.
        if (digit_evt) begin
          digits_d = digits_shifted;
          count_d  = count_inc;
          timer_d  = '0;
        end else if (confirm_evt) begin
          timer_d  = '0;
          state_d  = S_OUTPUT;
        end else if (timer_q == TIMER_LAST) begin
          digits_d = DIGITS_NONE;
          count_d  = '0;
          timer_d  = '0;
          tevt_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          // Unrecognised codes fall through here and do not restart the timer.
          timer_d  = timer_inc;
        end
      end

      S_OUTPUT: begin
        // Packet is frozen until the consumer takes it; keys are ignored.
        if (senha_ready) begin
          digits_d = DIGITS_NONE;
          count_d  = '0;
          timer_d  = '0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        digits_d = DIGITS_NONE;
        count_d  = '0;
        timer_d  = '0;
        state_d  = S_IDLE;
      end
    endcase

    // Disable acts as a synchronous clear and overrides everything above.
    if (!enable) begin
      digits_d = DIGITS_NONE;
      count_d  = '0;
      timer_d  = '0;
      tevt_d   = 1'b0;
      state_d  = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      digits_q <= DIGITS_NONE;
      count_q  <= '0;
      timer_q  <= '0;
      tevt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      tevt_q   <= tevt_d;
    end
  end

  // Edge detector history keeps tracking while disabled, so a key held across
  // re-enable is not mistaken for a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= key_valid;
    end
  end

  assign senha_digits = digits_q;
  assign senha_count  = count_q;
  assign senha_valid  = (state_q == S_OUTPUT);
  assign timeout_evt  = tevt_q;

endmodule

// File: tb/tb_password_entry_collector.sv
module tb_password_entry_collector;

  localparam int MAX_DIGITS     = 20;
  localparam int TIMEOUT_CYCLES = 5000;
  localparam int CW             = $clog2(MAX_DIGITS + 1);
  localparam int DW             = 4 * MAX_DIGITS;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          key_valid;
  logic [3:0]    key_value;
  logic [DW-1:0] senha_digits;
  logic [CW-1:0] senha_count;
  logic          senha_valid;
  logic          senha_ready;
  logic          timeout_evt;

  int checks;
  int errors;

  password_entry_collector #(
    .MAX_DIGITS     (MAX_DIGITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CONFIRM_KEY    (4'hA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .key_valid    (key_valid),
    .key_value    (key_value),
    .senha_digits (senha_digits),
    .senha_count  (senha_count),
    .senha_valid  (senha_valid),
    .senha_ready  (senha_ready),
    .timeout_evt  (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a key for 'hold' cycles, then release it for one cycle.
  task automatic press(input logic [3:0] v, input int hold);
    key_value = v;
    key_valid = 1'b1;
    repeat (hold) tick();
    key_valid = 1'b0;
    key_value = 4'hF;
    tick();
  endtask

  task automatic handshake();
    senha_ready = 1'b1;
    tick();
    senha_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] exp_d;
    exp_d = '1;
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (senha_count !== '0 || senha_valid !== 1'b0 || timeout_evt !== 1'b0 || senha_digits !== exp_d) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%b tevt=%b digits=%h required count=0 valid=0 tevt=0 digits=%h",
               senha_count, senha_valid, timeout_evt, senha_digits, exp_d);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_entry();
    logic [DW-1:0] exp_d;
    exp_d = '1;
    exp_d[11:0] = 12'h123;
    press(4'd1, 7);
    press(4'd2, 7);
    press(4'd3, 7);
    checks++;
    if (senha_valid !== 1'b0 || senha_count !== CW'(3)) begin
      errors++;
      $display("FAIL pre_confirm: valid=%b count=%0d required valid=0 count=3", senha_valid, senha_count);
    end
    press(4'hA, 2);
    checks++;
    if (senha_valid !== 1'b1 || senha_count !== CW'(3) || senha_digits !== exp_d) begin
      errors++;
      $display("FAIL confirm_123: valid=%b count=%0d digits=%h required valid=1 count=3 digits=%h",
               senha_valid, senha_count, senha_digits, exp_d);
    end
    handshake();
    exp_d = '1;
    checks++;
    if (senha_valid !== 1'b0 || senha_count !== '0 || senha_digits !== exp_d) begin
      errors++;
      $display("FAIL handshake_clear: valid=%b count=%0d digits=%h required valid=0 count=0 digits=%h",
               senha_valid, senha_count, senha_digits, exp_d);
    end
    $display("txn basic_entry 1,2,3,* -> handshake done");
  endtask

  task automatic test_long_hold();
    press(4'd5, 20);
    checks++;
    if (senha_count !== CW'(1) || senha_digits[7:0] !== 8'hF5) begin
      errors++;
      $display("FAIL long_hold: count=%0d low=%h required count=1 low=f5", senha_count, senha_digits[7:0]);
    end
    // Unrecognised code in COLLECT is ignored.
    press(4'hF, 2);
    press(4'hC, 2);
    checks++;
    if (senha_count !== CW'(1) || senha_digits[7:0] !== 8'hF5) begin
      errors++;
      $display("FAIL ignore_code: count=%0d low=%h required count=1 low=f5", senha_count, senha_digits[7:0]);
    end
    // ready outside OUTPUT has no effect.
    handshake();
    checks++;
    if (senha_count !== CW'(1) || senha_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_not_output: count=%0d valid=%b required count=1 valid=0", senha_count, senha_valid);
    end
    press(4'hA, 1);
    handshake();
    $display("txn long_hold value 5 held 20 cycles");
  endtask

  task automatic test_timeout();
    int pulses;
    int first_at;
    press(4'd4, 2);
    // Digit 8 accepted at the first edge; the release tick is idle cycle 1.
    press(4'd8, 1);
    pulses   = 0;
    first_at = -1;
    for (int i = 1; i <= TIMEOUT_CYCLES + 20; i++) begin
      tick();
      if (timeout_evt === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL timeout_pulses: got %0d required 1", pulses);
    end
    // TIMEOUT_CYCLES edges after the accepting edge; one was consumed by the release tick.
    checks++;
    if (first_at !== TIMEOUT_CYCLES - 1) begin
      errors++;
      $display("FAIL timeout_time: got %0d required %0d", first_at, TIMEOUT_CYCLES - 1);
    end
    checks++;
    if (senha_count !== '0 || senha_digits !== {DW{1'b1}}) begin
      errors++;
      $display("FAIL timeout_clear: count=%0d digits=%h required count=0 all f", senha_count, senha_digits);
    end
    press(4'hA, 2);
    tick();
    checks++;
    if (senha_valid !== 1'b0) begin
      errors++;
      $display("FAIL confirm_after_timeout: valid=%b required 0", senha_valid);
    end
    $display("txn timeout after 2 digits, pulses=%0d at cycle %0d", pulses, first_at);
  endtask

  task automatic test_overflow_and_freeze();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < MAX_DIGITS + 2; i++) press(4'(i % 10), 2);
    press(4'hA, 2);
    for (int k = 0; k < MAX_DIGITS; k++) exp_d[4*k +: 4] = 4'((MAX_DIGITS + 1 - k) % 10);
    checks++;
    if (senha_valid !== 1'b1 || senha_count !== CW'(MAX_DIGITS) || senha_digits !== exp_d) begin
      errors++;
      $display("FAIL overflow: valid=%b count=%0d digits=%h required valid=1 count=%0d digits=%h",
               senha_valid, senha_count, senha_digits, MAX_DIGITS, exp_d);
    end
    // Key events in OUTPUT are ignored, and no timeout runs there.
    press(4'd7, 3);
    repeat (5) tick();
    checks++;
    if (senha_valid !== 1'b1 || senha_count !== CW'(MAX_DIGITS) || senha_digits !== exp_d) begin
      errors++;
      $display("FAIL output_freeze: valid=%b count=%0d digits=%h required valid=1 count=%0d digits=%h",
               senha_valid, senha_count, senha_digits, MAX_DIGITS, exp_d);
    end
    handshake();
    checks++;
    if (senha_valid !== 1'b0 || senha_count !== '0) begin
      errors++;
      $display("FAIL overflow_release: valid=%b count=%0d required valid=0 count=0", senha_valid, senha_count);
    end
    $display("txn overflow %0d digits, newest=%h", MAX_DIGITS + 2, exp_d[3:0]);
  endtask

  task automatic test_async_reset_and_enable();
    press(4'd3, 2);
    press(4'd6, 2);
    // Assert reset 3ns after the edge, well away from any clock edge.
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (senha_count !== '0 || senha_digits !== {DW{1'b1}} || senha_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d digits=%h valid=%b required count=0 all f valid=0",
               senha_count, senha_digits, senha_valid);
    end
    tick();
    rst = 1'b1;
    tick();
    press(4'd2, 2);
    press(4'd9, 2);
    checks++;
    if (senha_count !== CW'(2) || senha_digits[7:0] !== 8'h29) begin
      errors++;
      $display("FAIL pre_disable: count=%0d low=%h required count=2 low=29", senha_count, senha_digits[7:0]);
    end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    checks++;
    if (senha_count !== '0 || senha_digits !== {DW{1'b1}}) begin
      errors++;
      $display("FAIL enable_clear: count=%0d digits=%h required count=0 all f", senha_count, senha_digits);
    end
    // Key pressed while disabled and held through re-enable must not register.
    enable = 1'b0;
    key_value = 4'd9;
    key_valid = 1'b1;
    tick();
    enable = 1'b1;
    repeat (3) tick();
    key_valid = 1'b0;
    key_value = 4'hF;
    tick();
    checks++;
    if (senha_count !== '0) begin
      errors++;
      $display("FAIL held_through_enable: count=%0d required 0", senha_count);
    end
    $display("txn async reset and enable clear");
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    enable      = 1'b1;
    key_valid   = 1'b0;
    key_value   = 4'hF;
    senha_ready = 1'b0;
    test_reset();
    test_basic_entry();
    test_long_hold();
    test_timeout();
    test_overflow_and_freeze();
    test_async_reset_and_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
